rf_writeback: RTL and testbench

Writeback-side controller for the pipelined CPU register file; it produces the file's single write port (write enable, write address, write data). It merges two write sources into one ordered write stream: the MEM/WB result and the `jal` link write to r31. Both sources can fire in the same cycle, so a small ordered queue holds the extra write and applies back-pressure to the pipeline when the queue nears full. Optional bypass outputs let the decode stage read values that are still queued.

---
 rtl/rf_wb_pkg.sv | 13 +
 rtl/rf_writeback_if.sv | 50 +++++
 rtl/wb_fifo.sv | 65 ++++++
 rtl/rf_writeback.sv | 135 +++++++++++++
 tb/tb_rf_writeback.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared constants and the queued write entry type for rf_writeback
package rf_wb_pkg;

  localparam int RF_DW       = 32;
  localparam int RF_AW       = 5;
  localparam int RF_LINK_REG = 31;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_writeback_if.sv
// rtl/rf_writeback_if.sv - pipeline <-> writeback controller bundle; bypass signals under RF_WB_BYPASS_EN
interface rf_writeback_if
  import rf_wb_pkg::*;
#(
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW,
  parameter int DEPTH = 4
);

  logic                     wb_valid;
  logic                     wb_ready;
  logic                     wb_regwrite;
  logic [AW-1:0]            wb_rd;
  logic                     wb_memtoreg;
  logic [DW-1:0]            wb_alu;
  logic [DW-1:0]            wb_load;
  logic                     jal;
  logic [DW-1:0]            jal_pc;
  logic                     rf_we;
  logic [AW-1:0]            rf_waddr;
  logic [DW-1:0]            rf_wdata;
  logic [$clog2(DEPTH):0]   pend_cnt;
`ifdef RF_WB_BYPASS_EN
  logic [AW-1:0]            rd_a1;
  logic [AW-1:0]            rd_a2;
  logic                     byp1_hit;
  logic                     byp2_hit;
  logic [DW-1:0]            byp1_data;
  logic [DW-1:0]            byp2_data;

  modport master (
    output wb_valid, wb_regwrite, wb_rd, wb_memtoreg, wb_alu, wb_load, jal, jal_pc, rd_a1, rd_a2,
    input  wb_ready, rf_we, rf_waddr, rf_wdata, pend_cnt, byp1_hit, byp2_hit, byp1_data, byp2_data
  );
  modport slave (
    input  wb_valid, wb_regwrite, wb_rd, wb_memtoreg, wb_alu, wb_load, jal, jal_pc, rd_a1, rd_a2,
    output wb_ready, rf_we, rf_waddr, rf_wdata, pend_cnt, byp1_hit, byp2_hit, byp1_data, byp2_data
  );
`else
  modport master (
    output wb_valid, wb_regwrite, wb_rd, wb_memtoreg, wb_alu, wb_load, jal, jal_pc,
    input  wb_ready, rf_we, rf_waddr, rf_wdata, pend_cnt
  );
  modport slave (
    input  wb_valid, wb_regwrite, wb_rd, wb_memtoreg, wb_alu, wb_load, jal, jal_pc,
    output wb_ready, rf_we, rf_waddr, rf_wdata, pend_cnt
  );
`endif

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular write queue, two pushes and one pop per cycle
// RF_WB_BYPASS_EN: also exposes every entry in age order for bypass matching
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push0_i,
  input  wb_entry_t       push0_data_i,
  input  logic            push1_i,
  input  wb_entry_t       push1_data_i,
  input  logic            pop_i,
  output wb_entry_t       head_o,
  output logic [CW-1:0]   count_o
`ifdef RF_WB_BYPASS_EN
  ,
  output wb_entry_t       ord_o [DEPTH],
  output logic [DEPTH-1:0] ord_vld_o
`endif
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  wb_entry_t     mem_q [DEPTH];

  // push1 is only ever asserted together with push0, so it always lands at tail+1
  assign head_d  = head_q + PW'(pop_i);
  assign tail_d  = tail_q + PW'(push0_i) + PW'(push1_i);
  assign count_d = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0_i) mem_q[tail_q] <= push0_data_i;
    if (push1_i) mem_q[tail_q + PW'(1)] <= push1_data_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

`ifdef RF_WB_BYPASS_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ord_o[i]     = mem_q[head_q + PW'(i)];
      ord_vld_o[i] = (CW'(i) < count_q);
    end
  end
`endif

endmodule

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - merges MEM/WB result and jal link into one ordered register-file write port
// RF_WB_BYPASS_EN: adds decode-stage bypass of still-pending writes
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  rf_writeback_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          ready;
  logic          res_en, link_en;
  wb_entry_t     res_e, link_e, new0_e, new1_e, head_e, out_e;
  wb_entry_t     push0_e, push1_e;
  logic          new0_v, new1_v, out_v, pop, push0, push1;
  logic [CW-1:0] count;

  logic          rf_we_q;
  logic [AW-1:0] rf_waddr_q;
  logic [DW-1:0] rf_wdata_q;

  // Two free slots are needed since a result and a link may both arrive
  assign ready   = (CW'(DEPTH) - count) >= CW'(2);
  assign res_en  = bus.wb_valid & ready & bus.wb_regwrite & (bus.wb_rd != '0);
  assign link_en = bus.jal & ready;
  assign res_e   = '{addr: bus.wb_rd, data: bus.wb_memtoreg ? bus.wb_load : bus.wb_alu};
  assign link_e  = '{addr: AW'(RF_LINK_REG), data: bus.jal_pc};

  always_comb begin
    new0_e  = res_en ? res_e : link_e;
    new0_v  = res_en | link_en;
    new1_e  = link_e;
    new1_v  = res_en & link_en;
    out_v   = 1'b0;
    out_e   = new0_e;
    pop     = 1'b0;
    push0   = 1'b0;
    push0_e = new0_e;
    push1   = 1'b0;
    push1_e = new1_e;
    if (count != '0) begin
      out_v   = 1'b1;
      out_e   = head_e;
      pop     = 1'b1;
      push0   = new0_v;
      push1   = new1_v;
    end else begin
      out_v   = new0_v;
      push0   = new1_v;
      push0_e = new1_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= out_v;
      if (out_v) begin
        rf_waddr_q <= out_e.addr;
        rf_wdata_q <= out_e.data;
      end
    end
  end

  assign bus.wb_ready = ready;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.pend_cnt = count;

`ifdef RF_WB_BYPASS_EN
  wb_entry_t        ord [DEPTH];
  logic [DEPTH-1:0] ord_vld;
  logic [AW-1:0]    rd_a [2];
  logic             hit  [2];
  logic [DW-1:0]    hdat [2];

  assign rd_a[0] = bus.rd_a1;
  assign rd_a[1] = bus.rd_a2;

  // Output register has lowest priority; later (newer) stored entries override older ones
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hit[p]  = 1'b0;
      hdat[p] = '0;
      if (rf_we_q && (rf_waddr_q == rd_a[p])) begin
        hit[p]  = 1'b1;
        hdat[p] = rf_wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (ord_vld[i] && (ord[i].addr == rd_a[p])) begin
          hit[p]  = 1'b1;
          hdat[p] = ord[i].data;
        end
      end
      if (rd_a[p] == '0) begin
        hit[p]  = 1'b0;
        hdat[p] = '0;
      end
    end
  end

  assign bus.byp1_hit  = hit[0];
  assign bus.byp2_hit  = hit[1];
  assign bus.byp1_data = hdat[0];
  assign bus.byp2_data = hdat[1];
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push0_i      (push0),
    .push0_data_i (push0_e),
    .push1_i      (push1),
    .push1_data_i (push1_e),
    .pop_i        (pop),
    .head_o       (head_e),
    .count_o      (count)
`ifdef RF_WB_BYPASS_EN
    ,
    .ord_o        (ord),
    .ord_vld_o    (ord_vld)
`endif
  );

endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - directed-vector bench for rf_writeback; bypass checks under RF_WB_BYPASS_EN
module tb_rf_writeback;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rf_writeback_if #(.DW(32), .AW(5), .DEPTH(4)) bus ();

  rf_writeback #(.DW(32), .AW(5), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid    = 1'b0;
    bus.wb_regwrite = 1'b0;
    bus.wb_rd       = '0;
    bus.wb_memtoreg = 1'b0;
    bus.wb_alu      = '0;
    bus.wb_load     = '0;
    bus.jal         = 1'b0;
    bus.jal_pc      = '0;
  endtask

  task automatic drive_res(input logic [4:0] rd, input logic m2r, input logic [31:0] alu,
                           input logic [31:0] ld);
    bus.wb_valid    = 1'b1;
    bus.wb_regwrite = 1'b1;
    bus.wb_rd       = rd;
    bus.wb_memtoreg = m2r;
    bus.wb_alu      = alu;
    bus.wb_load     = ld;
  endtask

  task automatic drive_jal(input logic [31:0] pc);
    bus.jal    = 1'b1;
    bus.jal_pc = pc;
  endtask

  logic [36:0] exp_q[$];
  logic [36:0] f;
  int          max_pend;
  bit          saw_stall;

  initial begin
    rst_n = 1'b0;
    idle();
`ifdef RF_WB_BYPASS_EN
    bus.rd_a1 = '0;
    bus.rd_a2 = '0;
`endif
    tick();
    tick();
    chk("rst_we",    64'(bus.rf_we),    64'd0);
    chk("rst_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("rst_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("rst_pend",  64'(bus.pend_cnt), 64'd0);
    chk("rst_ready", 64'(bus.wb_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // single write
    drive_res(5'd5, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF);
    tick();
    idle();
    chk("single_we",    64'(bus.rf_we),    64'd1);
    chk("single_waddr", 64'(bus.rf_waddr), 64'd5);
    chk("single_wdata", 64'(bus.rf_wdata), 64'h0000_1234);
    chk("single_pend",  64'(bus.pend_cnt), 64'd0);
    tick();
    chk("single_we_off", 64'(bus.rf_we),    64'd0);
    chk("single_hold",   64'(bus.rf_waddr), 64'd5);

    // result + link in the same cycle
    drive_res(5'd3, 1'b1, 32'h1111_1111, 32'hDEAD_BEEF);
    drive_jal(32'h0040_0008);
    tick();
    idle();
    chk("pair0_we",    64'(bus.rf_we),    64'd1);
    chk("pair0_waddr", 64'(bus.rf_waddr), 64'd3);
    chk("pair0_wdata", 64'(bus.rf_wdata), 64'hDEAD_BEEF);
    chk("pair0_pend",  64'(bus.pend_cnt), 64'd1);
    tick();
    chk("pair1_we",    64'(bus.rf_we),    64'd1);
    chk("pair1_waddr", 64'(bus.rf_waddr), 64'd31);
    chk("pair1_wdata", 64'(bus.rf_wdata), 64'h0040_0008);
    chk("pair1_pend",  64'(bus.pend_cnt), 64'd0);
    tick();
    chk("pair_done_we", 64'(bus.rf_we), 64'd0);

    // r0 and regwrite=0 produce nothing
    drive_res(5'd0, 1'b0, 32'h5555_5555, 32'h0);
    tick();
    chk("r0_we",   64'(bus.rf_we),    64'd0);
    chk("r0_pend", 64'(bus.pend_cnt), 64'd0);
    drive_res(5'd4, 1'b0, 32'h6666_6666, 32'h0);
    bus.wb_regwrite = 1'b0;
    tick();
    idle();
    chk("nowr_we",   64'(bus.rf_we),    64'd0);
    chk("nowr_pend", 64'(bus.pend_cnt), 64'd0);
    tick();
    chk("nowr_we2", 64'(bus.rf_we), 64'd0);

    // back-pressure: result+jal whenever ready, then drain
    max_pend  = 0;
    saw_stall = 1'b0;
    for (int c = 0; c < 18; c++) begin
      chk("bp_ready", 64'(bus.wb_ready), 64'((4 - exp_q.size()) >= 2));
      idle();
      if (bus.wb_ready && c < 8) begin
        drive_res(5'(c + 1), c[0], 32'h1000_0000 + c, 32'h2000_0000 + c);
        drive_jal(32'h0040_0000 + 4 * c);
        exp_q.push_back({5'(c + 1), c[0] ? 32'h2000_0000 + c : 32'h1000_0000 + c});
        exp_q.push_back({5'd31, 32'h0040_0000 + 4 * c});
      end else if (c < 8) begin
        saw_stall = 1'b1;
      end
      tick();
      idle();
      if (exp_q.size() > 0) begin
        f = exp_q.pop_front();
        chk("bp_we",    64'(bus.rf_we),    64'd1);
        chk("bp_waddr", 64'(bus.rf_waddr), 64'(f[36:32]));
        chk("bp_wdata", 64'(bus.rf_wdata), 64'(f[31:0]));
      end else begin
        chk("bp_idle_we", 64'(bus.rf_we), 64'd0);
      end
      chk("bp_pend", 64'(bus.pend_cnt), 64'(exp_q.size()));
      if (int'(bus.pend_cnt) > max_pend) max_pend = int'(bus.pend_cnt);
    end
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_stalled", 64'(saw_stall),    64'd1);
    chk("bp_max",     64'(max_pend),     64'd3);

`ifdef RF_WB_BYPASS_EN
    // out r9 | out r31a | out r7=1 with stored {r31b, r7=2}
    drive_res(5'd9, 1'b0, 32'h0000_0009, 32'h0);
    drive_jal(32'h0000_0A00);
    tick();
    drive_res(5'd7, 1'b0, 32'h0000_0001, 32'h0);
    drive_jal(32'h0000_0B00);
    tick();
    idle();
    drive_res(5'd7, 1'b0, 32'h0000_0002, 32'h0);
    bus.rd_a1 = 5'd7;
    bus.rd_a2 = 5'd0;
    tick();
    idle();
    chk("byp_out_r7", 64'(bus.rf_waddr),  64'd7);
    chk("byp1_hit",   64'(bus.byp1_hit),  64'd1);
    chk("byp1_data",  64'(bus.byp1_data), 64'd2);
    chk("byp2_hit0",  64'(bus.byp2_hit),  64'd0);
    bus.rd_a1 = 5'd9;
    bus.rd_a2 = 5'd31;
    #1;
    chk("byp1_miss",  64'(bus.byp1_hit),  64'd0);
    chk("byp2_hit31", 64'(bus.byp2_hit),  64'd1);
    chk("byp2_data",  64'(bus.byp2_data), 64'h0B00);
    bus.rd_a1 = '0;
    bus.rd_a2 = '0;
    tick();
    tick();
    tick();
    chk("byp_drain_pend", 64'(bus.pend_cnt), 64'd0);
`endif

    // reset asserted with three entries stored
    for (int c = 0; c < 3; c++) begin
      drive_res(5'(10 + c), 1'b0, 32'hA000_0000 + c, 32'h0);
      drive_jal(32'hB000_0000 + c);
      tick();
    end
    idle();
    chk("mid_pend3", 64'(bus.pend_cnt), 64'd3);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_we",    64'(bus.rf_we),    64'd0);
    chk("mid_rst_pend",  64'(bus.pend_cnt), 64'd0);
    chk("mid_rst_ready", 64'(bus.wb_ready), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_rst_we",   64'(bus.rf_we),    64'd0);
      chk("post_rst_pend", 64'(bus.pend_cnt), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
